// File: rtl/panda_risc_v_pkg.sv
// Shared definitions for the fetch-result path between the IFU and the instruction buffer.
// Holds bus widths, msg field positions, buffer state encodings and the exception test.
package panda_risc_v_pkg;

    localparam int IF_RES_DATA_W = 128;
    localparam int IF_RES_MSG_W  = 4;

    localparam int MSG_PRDT_JUMP = 3;
    localparam int MSG_ILLEGAL   = 2;
    localparam int MSG_ERR_LSB   = 0;

    typedef enum logic {
        IBUF_NORMAL     = 1'b0,
        IBUF_EXCPT_HOLD = 1'b1
    } ibuf_state_t;

    // A predicted jump alone is not an exception; only illegal or imem errors are.
    function automatic logic msg_is_excpt(input logic [IF_RES_MSG_W-1:0] msg);
        return msg[MSG_ILLEGAL] | (msg[MSG_ERR_LSB +: 2] != 2'b00);
    endfunction

endpackage

// File: rtl/panda_risc_v_fwft_fifo.sv
// Generic first-word-fall-through register FIFO with a synchronous flush.
// The caller must only assert wr_en when not full and rd_en when not empty.
module panda_risc_v_fwft_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 132,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Storage carries no reset; occupancy is tracked entirely by cnt.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (rd_en) begin
                rptr <= rptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    assign rd_data = mem[rptr];

endmodule

// File: rtl/panda_risc_v_if_res_buf.sv
// Instruction buffer between the IFU and decode: FWFT FIFO plus an exception-hold FSM
// that stops accepting fetch results after an excepting entry until the next flush.
module panda_risc_v_if_res_buf
    import panda_risc_v_pkg::*;
#(
    parameter  int IBUF_DEPTH = 4,
    localparam int CNT_W      = $clog2(IBUF_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     sys_resetn,
    input  logic                     flush_req,
    input  logic [IF_RES_DATA_W-1:0] s_if_res_data,
    input  logic [IF_RES_MSG_W-1:0]  s_if_res_msg,
    input  logic                     s_if_res_valid,
    output logic                     s_if_res_ready,
    output logic [IF_RES_DATA_W-1:0] m_ibuf_data,
    output logic [IF_RES_MSG_W-1:0]  m_ibuf_msg,
    output logic                     m_ibuf_valid,
    input  logic                     m_ibuf_ready,
    output logic [CNT_W-1:0]         ibuf_cnt,
    output logic                     ibuf_excpt_hold
);

    localparam int                 ENTRY_W  = IF_RES_DATA_W + IF_RES_MSG_W;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(IBUF_DEPTH);

    ibuf_state_t        state;
    ibuf_state_t        state_nxt;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;

    // Ready looks only at the registered count, so a same-cycle pop cannot reopen a full buffer.
    assign s_if_res_ready = (ibuf_cnt != FULL_CNT) & (state == IBUF_NORMAL) & ~flush_req & sys_resetn;
    assign m_ibuf_valid   = (ibuf_cnt != '0) & ~flush_req;

    assign push = s_if_res_valid & s_if_res_ready;
    assign pop  = m_ibuf_valid & m_ibuf_ready;

    panda_risc_v_fwft_fifo #(
        .DEPTH (IBUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (sys_resetn),
        .flush   (flush_req),
        .wr_en   (push),
        .wr_data ({s_if_res_data, s_if_res_msg}),
        .rd_en   (pop),
        .rd_data (head_entry),
        .cnt     (ibuf_cnt)
    );

    assign m_ibuf_data = head_entry[ENTRY_W-1:IF_RES_MSG_W];
    assign m_ibuf_msg  = head_entry[IF_RES_MSG_W-1:0];

    always_ff @(posedge clk) begin
        if (!sys_resetn) begin
            state <= IBUF_NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IBUF_NORMAL: begin
                if (flush_req) begin
                    state_nxt = IBUF_NORMAL;
                end else if (push && msg_is_excpt(s_if_res_msg)) begin
                    state_nxt = IBUF_EXCPT_HOLD;
                end
            end
            IBUF_EXCPT_HOLD: begin
                if (flush_req) begin
                    state_nxt = IBUF_NORMAL;
                end
            end
            default: state_nxt = IBUF_NORMAL;
        endcase
    end

    assign ibuf_excpt_hold = (state == IBUF_EXCPT_HOLD);

endmodule
